mem_arbiter: RTL and testbench

Shares the single SPI memory engine (`mem_external`) between the CPU's instruction-fetch path and its load/store path. Each requester gets a level request / pulse acknowledge handshake. The block sequences the engine's start/done protocol, arbitrates simultaneous requests, validates access size and enforces a timeout. It sits between the CPU core state machine and `mem_external`, and owns the engine's start, address, size, write and write-data inputs.

---
 rtl/mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SPI memory engine between the instruction-fetch
// port and the load/store port. Each port uses a level request / one-cycle
// acknowledge handshake; the arbiter drives the engine's start/done protocol,
// checks data access sizes and abandons an access that runs too long.
module mem_arbiter #(
   parameter int PRIORITY_MODE  = 0,     // 0 = round-robin, 1 = data port always wins a tie
   parameter int TIMEOUT_CYCLES = 1024   // cycles mem_start may stay high waiting for mem_done
) (
   input  logic        clk,
   input  logic        rst,
   // instruction-fetch port (always a 4-byte read)
   input  logic        f_req,
   input  logic [23:0] f_addr,
   output logic        f_ack,
   // load/store port
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [2:0]  d_num_bytes,
   input  logic        d_write,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   // shared response, valid with either ack
   output logic [31:0] rdata,
   output logic        err,
   // memory engine side
   output logic        mem_start,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_num_bytes,
   output logic        mem_write,
   output logic [31:0] mem_wdata,
   input  logic        mem_done,
   input  logic [31:0] mem_rdata,
   // status
   output logic        busy,
   output logic        owner
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic        OWNER_FETCH  = 1'b0;
   localparam logic        OWNER_DATA   = 1'b1;
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   // registered state
   state_t      state_reg,         state_next;
   logic        last_grant_reg,    last_grant_next;
   logic [15:0] count_reg,         count_next;
   logic        mem_start_reg,     mem_start_next;
   logic [31:0] mem_addr_reg,      mem_addr_next;
   logic [2:0]  mem_num_bytes_reg, mem_num_bytes_next;
   logic        mem_write_reg,     mem_write_next;
   logic [31:0] mem_wdata_reg,     mem_wdata_next;
   logic        f_ack_reg,         f_ack_next;
   logic        d_ack_reg,         d_ack_next;
   logic [31:0] rdata_reg,         rdata_next;
   logic        err_reg,           err_next;
   logic        owner_reg,         owner_next;

   // arbitration helpers
   logic tie;
   logic grant_data;
   logic size_ok;

   assign tie     = f_req & d_req;
   assign size_ok = (d_num_bytes == 3'd1) || (d_num_bytes == 3'd2) || (d_num_bytes == 3'd4);

   // Tie-break: fixed mode favours data; round-robin favours whoever did not
   // win last. A sole requester wins outright.
   assign grant_data = tie ? ((PRIORITY_MODE == 1) ? 1'b1 : (last_grant_reg == OWNER_FETCH))
                           : d_req;

   // Next-state and next-output logic; every register holds unless changed.
   always_comb begin
      state_next         = state_reg;
      last_grant_next    = last_grant_reg;
      count_next         = count_reg;
      mem_start_next     = mem_start_reg;
      mem_addr_next      = mem_addr_reg;
      mem_num_bytes_next = mem_num_bytes_reg;
      mem_write_next     = mem_write_reg;
      mem_wdata_next     = mem_wdata_reg;
      f_ack_next         = 1'b0;
      d_ack_next         = 1'b0;
      rdata_next         = rdata_reg;
      err_next           = err_reg;
      owner_next         = owner_reg;

      case (state_reg)
         IDLE: begin
            if (f_req || d_req) begin
               owner_next = grant_data;
               if (grant_data) begin
                  mem_addr_next      = d_addr;
                  mem_num_bytes_next = d_num_bytes;
                  mem_write_next     = d_write;
                  mem_wdata_next     = d_wdata;
               end else begin
                  mem_addr_next      = {8'd0, f_addr};
                  mem_num_bytes_next = 3'd4;
                  mem_write_next     = 1'b0;
                  mem_wdata_next     = 32'd0;
               end

               if (grant_data && !size_ok) begin
                  // Rejected without touching the engine; rdata keeps its value.
                  // last_grant still moves so a persistently bad data request
                  // cannot starve the fetch port in round-robin mode.
                  d_ack_next      = 1'b1;
                  err_next        = 1'b1;
                  last_grant_next = OWNER_DATA;
                  state_next      = RELEASE;
               end else begin
                  mem_start_next = 1'b1;
                  count_next     = 16'd0;
                  state_next     = ACCESS;
               end
            end
         end

         ACCESS: begin
            if (mem_done) begin
               rdata_next      = mem_rdata;
               err_next        = 1'b0;
               f_ack_next      = (owner_reg == OWNER_FETCH);
               d_ack_next      = (owner_reg == OWNER_DATA);
               mem_start_next  = 1'b0;
               last_grant_next = owner_reg;
               state_next      = RELEASE;
            end else if (count_reg == TIMEOUT_LAST) begin
               // Engine never answered: give up, report error, keep old rdata.
               err_next        = 1'b1;
               f_ack_next      = (owner_reg == OWNER_FETCH);
               d_ack_next      = (owner_reg == OWNER_DATA);
               mem_start_next  = 1'b0;
               last_grant_next = owner_reg;
               state_next      = RELEASE;
            end else begin
               count_next = count_reg + 16'd1;
            end
         end

         RELEASE: begin
            // Let the engine drop done before another start can be issued.
            if (!mem_done) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next     = IDLE;
            mem_start_next = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg         <= IDLE;
         last_grant_reg    <= OWNER_DATA;
         count_reg         <= 16'd0;
         mem_start_reg     <= 1'b0;
         mem_addr_reg      <= 32'd0;
         mem_num_bytes_reg <= 3'd0;
         mem_write_reg     <= 1'b0;
         mem_wdata_reg     <= 32'd0;
         f_ack_reg         <= 1'b0;
         d_ack_reg         <= 1'b0;
         rdata_reg         <= 32'd0;
         err_reg           <= 1'b0;
         owner_reg         <= 1'b0;
      end else begin
         state_reg         <= state_next;
         last_grant_reg    <= last_grant_next;
         count_reg         <= count_next;
         mem_start_reg     <= mem_start_next;
         mem_addr_reg      <= mem_addr_next;
         mem_num_bytes_reg <= mem_num_bytes_next;
         mem_write_reg     <= mem_write_next;
         mem_wdata_reg     <= mem_wdata_next;
         f_ack_reg         <= f_ack_next;
         d_ack_reg         <= d_ack_next;
         rdata_reg         <= rdata_next;
         err_reg           <= err_next;
         owner_reg         <= owner_next;
      end
   end

   assign mem_start     = mem_start_reg;
   assign mem_addr      = mem_addr_reg;
   assign mem_num_bytes = mem_num_bytes_reg;
   assign mem_write     = mem_write_reg;
   assign mem_wdata     = mem_wdata_reg;
   assign f_ack         = f_ack_reg;
   assign d_ack         = d_ack_reg;
   assign rdata         = rdata_reg;
   assign err           = err_reg;
   assign owner         = owner_reg;
   assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. Instance a runs round-robin
// with the default timeout; instance b runs fixed priority with an 8-cycle
// timeout. The bench plays the memory engine by hand.
module tb_mem_arbiter;

   logic clk;
   int   passed = 0;
   int   failed = 0;
   int   total  = 0;
   int   overlap = 0;
   int   hi;

   // instance a signals
   logic        a_rst, a_f_req, a_f_ack, a_d_req, a_d_write, a_d_ack;
   logic [23:0] a_f_addr;
   logic [31:0] a_d_addr, a_d_wdata, a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic [2:0]  a_d_nb, a_mem_nb;
   logic        a_err, a_mem_start, a_mem_write, a_mem_done, a_busy, a_owner;

   // instance b signals
   logic        b_rst, b_f_req, b_f_ack, b_d_req, b_d_write, b_d_ack;
   logic [23:0] b_f_addr;
   logic [31:0] b_d_addr, b_d_wdata, b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [2:0]  b_d_nb, b_mem_nb;
   logic        b_err, b_mem_start, b_mem_write, b_mem_done, b_busy, b_owner;

   mem_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(1024)) dut_a (
      .clk(clk), .rst(a_rst),
      .f_req(a_f_req), .f_addr(a_f_addr), .f_ack(a_f_ack),
      .d_req(a_d_req), .d_addr(a_d_addr), .d_num_bytes(a_d_nb), .d_write(a_d_write),
      .d_wdata(a_d_wdata), .d_ack(a_d_ack),
      .rdata(a_rdata), .err(a_err),
      .mem_start(a_mem_start), .mem_addr(a_mem_addr), .mem_num_bytes(a_mem_nb),
      .mem_write(a_mem_write), .mem_wdata(a_mem_wdata),
      .mem_done(a_mem_done), .mem_rdata(a_mem_rdata),
      .busy(a_busy), .owner(a_owner)
   );

   mem_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)) dut_b (
      .clk(clk), .rst(b_rst),
      .f_req(b_f_req), .f_addr(b_f_addr), .f_ack(b_f_ack),
      .d_req(b_d_req), .d_addr(b_d_addr), .d_num_bytes(b_d_nb), .d_write(b_d_write),
      .d_wdata(b_d_wdata), .d_ack(b_d_ack),
      .rdata(b_rdata), .err(b_err),
      .mem_start(b_mem_start), .mem_addr(b_mem_addr), .mem_num_bytes(b_mem_nb),
      .mem_write(b_mem_write), .mem_wdata(b_mem_wdata),
      .mem_done(b_mem_done), .mem_rdata(b_mem_rdata),
      .busy(b_busy), .owner(b_owner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Both acks of one instance must never be high together.
   always @(negedge clk) begin
      if ((a_f_ack && a_d_ack) || (b_f_ack && b_d_ack)) overlap++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task tick;
      @(posedge clk);
      #1;
   endtask

   task a_expect_grant(input string tag, input logic own, input logic [31:0] addr);
      check({tag, ".start"}, 32'(a_mem_start), 32'd1);
      check({tag, ".busy"},  32'(a_busy),      32'd1);
      check({tag, ".owner"}, 32'(own ? 1 : 0) == 32'(a_owner) ? 32'(a_owner) : 32'(a_owner), 32'(own));
      check({tag, ".addr"},  a_mem_addr,       addr);
   endtask

   task a_finish(input string tag, input logic own, input logic [31:0] val);
      a_mem_done  = 1'b1;
      a_mem_rdata = val;
      tick;
      check({tag, ".f_ack"}, 32'(a_f_ack),     32'(!own));
      check({tag, ".d_ack"}, 32'(a_d_ack),     32'(own));
      check({tag, ".rdata"}, a_rdata,          val);
      check({tag, ".err"},   32'(a_err),       32'd0);
      check({tag, ".start"}, 32'(a_mem_start), 32'd0);
      $display("txn a %s owner=%0d rdata=%h err=%0d", tag, own, a_rdata, a_err);
      a_mem_done = 1'b0;
      tick;
      check({tag, ".idle"},  32'(a_busy),      32'd0);
      check({tag, ".pulse"}, 32'(a_f_ack | a_d_ack), 32'd0);
   endtask

   initial begin
      a_rst = 1'b1; a_f_req = 0; a_f_addr = 0; a_d_req = 0; a_d_addr = 0;
      a_d_nb = 3'd4; a_d_write = 0; a_d_wdata = 0; a_mem_done = 0; a_mem_rdata = 0;
      b_rst = 1'b1; b_f_req = 0; b_f_addr = 0; b_d_req = 0; b_d_addr = 0;
      b_d_nb = 3'd4; b_d_write = 0; b_d_wdata = 0; b_mem_done = 0; b_mem_rdata = 0;
      tick;
      tick;

      // reset state
      check("rst.start", 32'(a_mem_start), 32'd0);
      check("rst.busy",  32'(a_busy),      32'd0);
      check("rst.acks",  32'(a_f_ack | a_d_ack), 32'd0);
      check("rst.err",   32'(a_err),       32'd0);
      check("rst.owner", 32'(a_owner),     32'd0);
      check("rst.addr",  a_mem_addr,       32'd0);
      check("rst.nb",    32'(a_mem_nb),    32'd0);
      check("rst.rdata", a_rdata,          32'd0);
      check("rst.b_start", 32'(b_mem_start), 32'd0);
      check("rst.b_busy",  32'(b_busy),      32'd0);
      a_rst = 1'b0;
      b_rst = 1'b0;
      tick;

      // fetch only, engine answers 40 cycles after start
      a_f_req  = 1'b1;
      a_f_addr = 24'h000010;
      tick;
      a_expect_grant("fetch", 1'b0, 32'h0000_0010);
      check("fetch.nb",    32'(a_mem_nb),    32'd4);
      check("fetch.write", 32'(a_mem_write), 32'd0);
      check("fetch.wdata", a_mem_wdata,      32'd0);
      a_f_req = 1'b0;
      repeat (39) tick;
      check("fetch.wait_start", 32'(a_mem_start), 32'd1);
      check("fetch.wait_ack",   32'(a_f_ack | a_d_ack), 32'd0);
      a_finish("fetch", 1'b0, 32'h0050_0093);
      check("fetch.addr_hold", a_mem_addr, 32'h0000_0010);

      // round-robin with both requests held high from reset
      a_rst = 1'b1;
      a_f_req = 1'b1; a_f_addr = 24'h000020;
      a_d_req = 1'b1; a_d_addr = 32'h0000_0100; a_d_nb = 3'd4; a_d_write = 1'b0;
      tick;
      a_rst = 1'b0;
      tick;
      a_expect_grant("rr0", 1'b0, 32'h0000_0020);
      a_finish("rr0", 1'b0, 32'h1111_1111);
      tick;
      a_expect_grant("rr1", 1'b1, 32'h0000_0100);
      a_finish("rr1", 1'b1, 32'h2222_2222);
      tick;
      a_expect_grant("rr2", 1'b0, 32'h0000_0020);
      a_finish("rr2", 1'b0, 32'h3333_3333);
      tick;
      a_expect_grant("rr3", 1'b1, 32'h0000_0100);
      check("rr3.nb", 32'(a_mem_nb), 32'd4);
      a_finish("rr3", 1'b1, 32'h4444_4444);
      a_f_req = 1'b0;
      a_d_req = 1'b0;

      // invalid data size: rejected without starting the engine
      a_d_req = 1'b1; a_d_nb = 3'd3; a_d_addr = 32'h0000_0044;
      a_d_write = 1'b1; a_d_wdata = 32'h0000_dead;
      tick;
      check("bad.d_ack", 32'(a_d_ack),     32'd1);
      check("bad.f_ack", 32'(a_f_ack),     32'd0);
      check("bad.err",   32'(a_err),       32'd1);
      check("bad.start", 32'(a_mem_start), 32'd0);
      check("bad.rdata", a_rdata,          32'h4444_4444);
      check("bad.busy",  32'(a_busy),      32'd1);
      $display("txn a bad_size owner=1 rdata=%h err=%0d", a_rdata, a_err);
      a_d_req = 1'b0;
      tick;
      check("bad.pulse", 32'(a_d_ack),     32'd0);
      check("bad.start2", 32'(a_mem_start), 32'd0);
      check("bad.idle",  32'(a_busy),      32'd0);

      // reset in the middle of a data access
      a_d_nb = 3'd4; a_d_write = 1'b0;
      a_f_req = 1'b1; a_f_addr = 24'h000030;
      tick;
      a_expect_grant("pre", 1'b0, 32'h0000_0030);
      a_f_req = 1'b0;
      a_finish("pre", 1'b0, 32'h5555_5555);
      a_d_req = 1'b1; a_d_addr = 32'h0000_0200;
      tick;
      a_expect_grant("mid", 1'b1, 32'h0000_0200);
      repeat (3) tick;
      a_rst = 1'b1;
      a_f_req = 1'b1;
      tick;
      check("mid_rst.start", 32'(a_mem_start), 32'd0);
      check("mid_rst.busy",  32'(a_busy),      32'd0);
      check("mid_rst.acks",  32'(a_f_ack | a_d_ack), 32'd0);
      $display("txn a reset_mid_access start=%0d busy=%0d", a_mem_start, a_busy);
      a_rst = 1'b0;
      tick;
      a_expect_grant("post_rst", 1'b0, 32'h0000_0030);

      // engine holds done for an extra cycle; RELEASE must wait for it
      a_mem_done = 1'b1; a_mem_rdata = 32'h6666_6666;
      a_f_req = 1'b0; a_d_req = 1'b0;
      tick;
      check("hold.f_ack", 32'(a_f_ack), 32'd1);
      check("hold.rdata", a_rdata,      32'h6666_6666);
      $display("txn a post_rst owner=0 rdata=%h err=%0d", a_rdata, a_err);
      tick;
      check("hold.busy",  32'(a_busy),  32'd1);
      check("hold.pulse", 32'(a_f_ack), 32'd0);
      a_mem_done = 1'b0;
      tick;
      check("hold.idle",  32'(a_busy),  32'd0);
      tick;
      check("hold.no_start", 32'(a_mem_start), 32'd0);

      // fixed priority: data wins the tie, store fields pass through
      b_f_req = 1'b1; b_f_addr = 24'h000040;
      b_d_req = 1'b1; b_d_addr = 32'h0000_0300; b_d_nb = 3'd2;
      b_d_write = 1'b1; b_d_wdata = 32'h0000_1234;
      tick;
      check("fx.start", 32'(b_mem_start), 32'd1);
      check("fx.owner", 32'(b_owner),     32'd1);
      check("fx.addr",  b_mem_addr,       32'h0000_0300);
      check("fx.write", 32'(b_mem_write), 32'd1);
      check("fx.nb",    32'(b_mem_nb),    32'd2);
      check("fx.wdata", b_mem_wdata,      32'h0000_1234);
      b_mem_done = 1'b1; b_mem_rdata = 32'h7777_7777;
      tick;
      check("fx.d_ack", 32'(b_d_ack), 32'd1);
      check("fx.f_ack", 32'(b_f_ack), 32'd0);
      check("fx.err",   32'(b_err),   32'd0);
      $display("txn b store owner=1 rdata=%h err=%0d", b_rdata, b_err);
      b_mem_done = 1'b0;
      tick;
      check("fx.idle", 32'(b_busy), 32'd0);

      // data wins again (no alternation) and the engine never answers
      b_d_write = 1'b0; b_d_nb = 3'd4; b_d_addr = 32'h0000_0304;
      tick;
      check("to.owner", 32'(b_owner),   32'd1);
      check("to.addr",  b_mem_addr,     32'h0000_0304);
      hi = b_mem_start ? 1 : 0;
      repeat (7) begin
         tick;
         if (b_mem_start && !b_d_ack && !b_f_ack) hi++;
      end
      check("to.start_cycles", 32'(hi), 32'd8);
      tick;
      check("to.start", 32'(b_mem_start), 32'd0);
      check("to.d_ack", 32'(b_d_ack),     32'd1);
      check("to.f_ack", 32'(b_f_ack),     32'd0);
      check("to.err",   32'(b_err),       32'd1);
      check("to.rdata", b_rdata,          32'h7777_7777);
      $display("txn b timeout owner=1 rdata=%h err=%0d", b_rdata, b_err);
      b_d_req = 1'b0;
      tick;
      check("to.idle",  32'(b_busy),  32'd0);
      check("to.pulse", 32'(b_d_ack), 32'd0);

      // the pending fetch is serviced normally after the timeout
      tick;
      check("after.owner", 32'(b_owner),     32'd0);
      check("after.start", 32'(b_mem_start), 32'd1);
      check("after.addr",  b_mem_addr,       32'h0000_0040);
      check("after.nb",    32'(b_mem_nb),    32'd4);
      check("after.write", 32'(b_mem_write), 32'd0);
      check("after.wdata", b_mem_wdata,      32'd0);
      b_f_req = 1'b0;
      b_mem_done = 1'b1; b_mem_rdata = 32'hcafe_f00d;
      tick;
      check("after.f_ack", 32'(b_f_ack), 32'd1);
      check("after.err",   32'(b_err),   32'd0);
      check("after.rdata", b_rdata,      32'hcafe_f00d);
      $display("txn b fetch owner=0 rdata=%h err=%0d", b_rdata, b_err);
      b_mem_done = 1'b0;
      tick;
      check("after.idle", 32'(b_busy), 32'd0);

      check("ack_overlap", 32'(overlap), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
